// File: rtl/xy_mult_seq.sv
// xy_mult_seq: bus-mapped sequential shift-add multiplier of (A+B)*(A-B) or A*B
module xy_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 E,
  input  logic                 W,
  input  logic                 R,
  input  logic [1:0]           ADDR,
  input  logic [WIDTH-1:0]     D,
  output logic [2*WIDTH-1:0]   OUT,
  output logic                 BUSY,
  output logic                 DONE
);
  typedef enum logic [1:0] {IDLE, RUN, CMPL} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a, b, x, y;
  logic [2*WIDTH-1:0] acc, result, term, rd;
  logic [CW-1:0] cnt;
  logic mode, start, last;
  assign start = E && W && ADDR == 2'd3 && D[0];
  assign last  = cnt == CW'(WIDTH - 1);
  // partial product for the multiplier bit handled this edge
  always_comb term = x[cnt] ? ({{WIDTH{1'b0}}, y} << cnt) : '0;
  // read mux sees pre-edge register values, so read-during-write returns old data
  always_comb rd = ADDR == 2'd0 ? {{WIDTH{1'b0}}, a} :
                   ADDR == 2'd1 ? {{WIDTH{1'b0}}, b} :
                   ADDR == 2'd2 ? result :
                   {{(2*WIDTH-3){1'b0}}, mode, DONE, BUSY};
  // bus registers, control FSM and shift-add datapath
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      x      <= '0;
      y      <= '0;
      acc    <= '0;
      result <= '0;
      cnt    <= '0;
      mode   <= 1'b0;
      OUT    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      if (E && R) OUT <= rd;
      if (E && W && ADDR == 2'd0) a <= D;
      if (E && W && ADDR == 2'd1) b <= D;
      case (state)
        RUN: begin
          acc <= acc + term;
          cnt <= cnt + 1'b1;
          if (last) begin
            result <= acc + term;
            state  <= CMPL;
            BUSY   <= 1'b0;
            DONE   <= 1'b1;
          end
        end
        default: if (start) begin
          mode  <= D[1];
          x     <= D[1] ? a : a + b;
          y     <= D[1] ? b : a - b;
          acc   <= '0;
          cnt   <= '0;
          state <= RUN;
          BUSY  <= 1'b1;
          DONE  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xy_mult_seq.sv
// tb_xy_mult_seq: directed and random checks of xy_mult_seq against an arithmetic model
module tb_xy_mult_seq;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        E = 1'b0, W = 1'b0, R = 1'b0;
  logic [1:0]  ADDR = '0;
  logic [15:0] D = '0;
  logic [31:0] OUT;
  logic        BUSY, DONE;
  int vectors = 0;
  int miscompares = 0;

  xy_mult_seq #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .E(E), .W(W), .R(R),
    .ADDR(ADDR), .D(D), .OUT(OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b, input logic m);
    logic [15:0] x, y;
    x = m ? a : a + b;
    y = m ? b : a - b;
    return {16'b0, x} * {16'b0, y};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic r, input logic [1:0] ad, input logic [15:0] d);
    E = 1'b1; W = w; R = r; ADDR = ad; D = d;
    @(posedge CLK); #1;
    E = 1'b0; W = 1'b0; R = 1'b0;
  endtask

  task automatic wait_done(inout int n);
    while (!DONE && n < 64) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic m,
                        input logic [31:0] exp, input string tag);
    int n = 0;
    bus(1, 0, 2'd0, a);
    bus(1, 0, 2'd1, b);
    bus(1, 0, 2'd3, {14'b0, m, 1'b1});
    check({tag, " busy"}, {30'b0, DONE, BUSY}, 32'h1);
    wait_done(n);
    check({tag, " latency"}, n, 16);
    check({tag, " flags"}, {30'b0, DONE, BUSY}, 32'h2);
    bus(0, 1, 2'd2, 16'h0);
    check({tag, " result"}, OUT, exp);
  endtask

  initial begin
    int n;
    logic [15:0] ra, rb;
    logic rm;
    repeat (2) @(posedge CLK);
    #1;
    check("reset out", OUT, 32'h0);
    check("reset flags", {30'b0, DONE, BUSY}, 32'h0);
    #3 RST_N = 1'b1;
    @(posedge CLK); #1;
    bus(0, 1, 2'd3, 16'h0);
    check("reset status", OUT, 32'h0);

    run_op(16'd5, 16'd4, 1'b0, 32'd9, "a5b4");
    run_op(16'd445, 16'd100, 1'b0, 32'd188025, "a445b100");
    run_op(16'd4, 16'd5, 1'b0, 32'd589815, "wrapY");
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'd0, "max m0");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'hFFFE0001, "max m1");
    bus(0, 1, 2'd3, 16'h0);
    check("status m1 done", OUT, 32'h6);

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rm = 1'($urandom);
      run_op(ra, rb, rm, model(ra, rb, rm), "random");
    end

    bus(1, 0, 2'd0, 16'd300);
    bus(1, 0, 2'd1, 16'd77);
    bus(1, 0, 2'd3, 16'h1);
    n = 0;
    repeat (2) begin
      @(posedge CLK); #1;
      n++;
    end
    bus(1, 0, 2'd3, 16'h3);
    n++;
    bus(1, 0, 2'd0, 16'd7);
    n++;
    check("inflight busy", {31'b0, BUSY}, 32'h1);
    wait_done(n);
    check("inflight latency", n, 16);
    bus(0, 1, 2'd2, 16'h0);
    check("inflight result", OUT, model(16'd300, 16'd77, 1'b0));
    bus(0, 1, 2'd3, 16'h0);
    check("inflight mode kept", OUT, 32'h2);
    bus(0, 1, 2'd0, 16'h0);
    check("A updated", OUT, 32'd7);

    bus(1, 0, 2'd3, 16'h3);
    repeat (8) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("abort flags", {30'b0, DONE, BUSY}, 32'h0);
    check("abort out", OUT, 32'h0);
    @(negedge CLK) RST_N = 1'b1;
    @(posedge CLK); #1;
    bus(0, 1, 2'd2, 16'h0);
    check("abort result", OUT, 32'h0);
    bus(0, 1, 2'd0, 16'h0);
    check("abort A", OUT, 32'h0);
    run_op(16'd1234, 16'd56, 1'b1, model(16'd1234, 16'd56, 1'b1), "after abort");

    bus(0, 1, 2'd0, 16'h0);
    check("read A", OUT, 32'd1234);
    E = 1'b0; R = 1'b1; ADDR = 2'd2;
    @(posedge CLK); #1;
    R = 1'b0;
    check("E=0 hold", OUT, 32'd1234);
    bus(1, 1, 2'd0, 16'd999);
    check("rd-wr old A", OUT, 32'd1234);
    bus(0, 1, 2'd0, 16'h0);
    check("rd new A", OUT, 32'd999);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/xy_mult_seq.md
XY_MULT_SEQ -- requirements
Module: xy_mult_seq

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits; legal range 4..32.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 E  input  1  bus enable; W and R are ignored while E=0.
REQ-005 W  input  1  write strobe, qualified by E.
REQ-006 R  input  1  read strobe, qualified by E.
REQ-007 ADDR  input  2  register select: 0=A, 1=B, 2=RESULT (read-only), 3=CTRL/STATUS.
REQ-008 D  input  WIDTH  write data.
REQ-009 OUT  output  2*WIDTH  registered read data.
REQ-010 BUSY  output  1  high while a multiplication is in progress.
REQ-011 DONE  output  1  high when RESULT holds a completed product not yet superseded by a new start.

Function
REQ-012 Write on rising edge when E=1 and W=1: ADDR 0 loads A=D; ADDR 1 loads B=D; ADDR 2 has no effect; ADDR 3 is a command (D[0]=START, D[1]=MODE).
REQ-013 Read on rising edge when E=1 and R=1: OUT loads the zero-extended A (ADDR 0), zero-extended B (ADDR 1), RESULT (ADDR 2), or status {zeros, MODE, DONE, BUSY} in bits [2:0] (ADDR 3).
REQ-014 OUT holds its value on every edge without a qualified read.
REQ-015 Simultaneous read and write of the same address on one edge: OUT returns the pre-write value.
REQ-016 State machine with states IDLE, RUN and CMPL; BUSY=1 only in RUN; DONE=1 only in CMPL.
REQ-017 A command with START=1 in IDLE or CMPL: latches MODE, snapshots operands X and Y, clears the accumulator and the bit counter, and enters RUN on the same edge.
REQ-018 MODE=0 operand snapshot: X=(A+B) mod 2^WIDTH and Y=(A-B) mod 2^WIDTH, both unsigned.
REQ-019 MODE=1 operand snapshot: X=A and Y=B.
REQ-020 Each RUN edge handles one multiplier bit i (i = 0..WIDTH-1): if X[i]=1, the accumulator gains Y shifted left by i, computed in 2*WIDTH bits unsigned; no overflow is possible.
REQ-021 After exactly WIDTH RUN edges, the final edge writes the product to RESULT and moves RUN -> CMPL.
REQ-022 Latency: START captured at edge k gives BUSY=1 from after edge k, and RESULT valid with DONE=1 and BUSY=0 after edge k+WIDTH.
REQ-023 START=1 while in RUN is ignored: MODE, operands and counter are unaffected.
REQ-024 A command with START=0 has no effect on the state machine or on MODE.
REQ-025 Writes to A or B during RUN update the registers but do not affect the in-flight product.
REQ-026 RESULT keeps its previous value until the next completion, and is readable in every state.
REQ-027 CMPL persists until the next accepted START.
REQ-028 E=0 stalls only bus access; the computation proceeds.

Reset
REQ-029 RST_N=0 asynchronously forces: state IDLE; A, B, MODE, RESULT, accumulator, counter and OUT to 0; BUSY=0; DONE=0.
REQ-030 Reset asserted during RUN aborts the operation; no partial product ever reaches RESULT.
REQ-031 First START is accepted on the first rising edge after RST_N deasserts.

Verification (WIDTH=16)
REQ-032 A=5, B=4, CTRL=0x1 -> after 16 RUN edges DONE=1; RESULT read returns 9.
REQ-033 A=445, B=100, MODE=0 -> RESULT=188025; A=4, B=5, MODE=0 (wrapped Y=65535) -> RESULT=589815.
REQ-034 A=65535, B=65535: MODE=0 -> RESULT=0; MODE=1 (CTRL=0x3) -> RESULT=0xFFFE0001; status read returns 0b110.
REQ-035 Second START plus write A=7 issued 3 edges into RUN -> both ignored by the in-flight op; BUSY stays high for exactly 16 edges; RESULT matches the original operands.
REQ-036 RST_N pulsed low at RUN edge 8 -> BUSY=0, DONE=0, OUT=0, RESULT=0 immediately; a fresh START afterwards completes normally.
REQ-037 Read ADDR 2 with E=0 -> OUT unchanged; write A with R=1 at ADDR 0 on the same edge -> OUT shows the old A.
